// File: rtl/apu_pkg.sv
// Shared APU constants: register addresses, frame-mode encoding and
// the default NTSC frame-step cycle counts.
package apu_pkg;

    localparam logic [15:0] ADDR_TRI_LINEAR = 16'h4008;
    localparam logic [15:0] ADDR_TRI_TLO    = 16'h400A;
    localparam logic [15:0] ADDR_TRI_THI    = 16'h400B;
    localparam logic [15:0] ADDR_STATUS     = 16'h4015;
    localparam logic [15:0] ADDR_FRAME      = 16'h4017;

    typedef enum logic {
        FOUR_STEP = 1'b0,
        FIVE_STEP = 1'b1
    } frame_mode_t;

    localparam int STEP1_DEFAULT = 7457;
    localparam int STEP2_DEFAULT = 14913;
    localparam int STEP3_DEFAULT = 22371;
    localparam int STEP4_DEFAULT = 29829;
    localparam int STEP5_DEFAULT = 37281;

endpackage

// File: rtl/apu_frame_control_if.sv
// CPU-side register bus into the APU front end.
// Strobe semantics: there is no valid/ready handshake; the slave samples
// we and re on every clk edge and each high cycle is exactly one access at
// addr (with wdata for writes). The slave never stalls the master.
interface apu_frame_control_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;

    modport master (output addr, output wdata, output we, output re);
    modport slave  (input  addr, input  wdata, input  we, input  re);
endinterface

// File: rtl/frame_sequencer.sv
// NES frame counter: cycle count, 4/5-step mode, step decode and the
// registered quarter/half-frame strobes. CW must satisfy STEP5 < 2**CW.
module frame_sequencer import apu_pkg::*; #(
    parameter int STEP1 = STEP1_DEFAULT,
    parameter int STEP2 = STEP2_DEFAULT,
    parameter int STEP3 = STEP3_DEFAULT,
    parameter int STEP4 = STEP4_DEFAULT,
    parameter int STEP5 = STEP5_DEFAULT,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_ce,
    input  logic          frame_wr,
    input  frame_mode_t   wr_mode,
    input  logic          wr_inhibit,
    output logic          quarter_frame,
    output logic          half_frame,
    output logic          irq_set,
    output frame_mode_t   mode,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] S1 = CW'(STEP1);
    localparam logic [CW-1:0] S2 = CW'(STEP2);
    localparam logic [CW-1:0] S3 = CW'(STEP3);
    localparam logic [CW-1:0] S4 = CW'(STEP4);
    localparam logic [CW-1:0] S5 = CW'(STEP5);

    frame_mode_t   mode_q;
    logic          inhibit_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          quarter_q, half_q;
    logic          at_last, q_hit, h_hit;

    // Step decode for the current mode; the last step of the mode wraps cnt.
    always_comb begin
        at_last = (mode_q == FOUR_STEP) ? (cnt_q == S4) : (cnt_q == S5);
        q_hit   = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || at_last;
        h_hit   = (cnt_q == S2) || at_last;
        cnt_d   = at_last ? '0 : cnt_q + 1'b1;
        // A $4017 write on the same edge wins over the step-4 IRQ.
        irq_set = cpu_ce && !frame_wr && (mode_q == FOUR_STEP) &&
                  (cnt_q == S4) && !inhibit_q;
    end

    // Mode/count state and registered strobes; a $4017 write restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= FOUR_STEP;
            inhibit_q <= 1'b0;
            cnt_q     <= '0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end else if (frame_wr) begin
            mode_q    <= wr_mode;
            inhibit_q <= wr_inhibit;
            cnt_q     <= '0;
            quarter_q <= (wr_mode == FIVE_STEP);
            half_q    <= (wr_mode == FIVE_STEP);
        end else if (cpu_ce) begin
            cnt_q     <= cnt_d;
            quarter_q <= q_hit;
            half_q    <= h_hit;
        end else begin
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end
    end

    assign quarter_frame = quarter_q;
    assign half_frame    = half_q;
    assign mode          = mode_q;
    assign cnt           = cnt_q;

endmodule

// File: rtl/apu_frame_control.sv
// Triangle-channel front end: decodes CPU writes to the triangle and frame
// registers, holds the register bytes, and owns the frame IRQ flag.
module apu_frame_control import apu_pkg::*; #(
    parameter int STEP1 = STEP1_DEFAULT,
    parameter int STEP2 = STEP2_DEFAULT,
    parameter int STEP3 = STEP3_DEFAULT,
    parameter int STEP4 = STEP4_DEFAULT,
    parameter int STEP5 = STEP5_DEFAULT,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_ce,
    apu_frame_control_if.slave  bus,
    output logic [7:0]          inputReg1,
    output logic [7:0]          inputReg2,
    output logic [7:0]          inputReg3,
    output logic                linear_reload,
    output logic                quarter_frame,
    output logic                half_frame,
    output logic                frame_irq,
    output frame_mode_t         dbg_mode,
    output logic [CW-1:0]       dbg_cnt
);

    logic [7:0] reg1_q, reg2_q, reg3_q;
    logic       linear_reload_q;
    logic       frame_irq_q, frame_irq_d;
    logic       wr_lin, wr_tlo, wr_thi, frame_wr, irq_clr, irq_set;

    // Address decode and IRQ next state; a set on the same edge beats a clear.
    always_comb begin
        wr_lin   = bus.we && (bus.addr == ADDR_TRI_LINEAR);
        wr_tlo   = bus.we && (bus.addr == ADDR_TRI_TLO);
        wr_thi   = bus.we && (bus.addr == ADDR_TRI_THI);
        frame_wr = bus.we && (bus.addr == ADDR_FRAME);
        irq_clr  = (bus.re && (bus.addr == ADDR_STATUS)) ||
                   (frame_wr && bus.wdata[6]);
        frame_irq_d = frame_irq_q;
        if (irq_clr) frame_irq_d = 1'b0;
        if (irq_set) frame_irq_d = 1'b1;
    end

    // Triangle register bytes, linear-reload strobe and IRQ flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg1_q          <= 8'h00;
            reg2_q          <= 8'h00;
            reg3_q          <= 8'h00;
            linear_reload_q <= 1'b0;
            frame_irq_q     <= 1'b0;
        end else begin
            if (wr_lin) reg1_q <= bus.wdata;
            if (wr_tlo) reg2_q <= bus.wdata;
            if (wr_thi) reg3_q <= bus.wdata;
            linear_reload_q <= wr_thi;
            frame_irq_q     <= frame_irq_d;
        end
    end

    frame_sequencer #(
        .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3),
        .STEP4(STEP4), .STEP5(STEP5), .CW(CW)
    ) u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_ce        (cpu_ce),
        .frame_wr      (frame_wr),
        .wr_mode       (frame_mode_t'(bus.wdata[7])),
        .wr_inhibit    (bus.wdata[6]),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .irq_set       (irq_set),
        .mode          (dbg_mode),
        .cnt           (dbg_cnt)
    );

    assign inputReg1     = reg1_q;
    assign inputReg2     = reg2_q;
    assign inputReg3     = reg3_q;
    assign linear_reload = linear_reload_q;
    assign frame_irq     = frame_irq_q;

endmodule

// File: doc/apu_frame_control.md
# apu_frame_control

Front end for the APU triangle channel. It decodes CPU register writes to $4008, $400A, $400B and $4017, and holds the three triangle register bytes. It also runs the NES frame counter, which produces the quarter-frame and half-frame strobes for the triangle channel's linear and length counter clocks. It raises the frame IRQ.

## Interface
Parameters:
- STEP1, default 7457: CPU cycles to frame step 1.
- STEP2, default 14913: CPU cycles to step 2.
- STEP3, default 22371: CPU cycles to step 3.
- STEP4, default 29829: CPU cycles to step 4, the last step in 4-step mode.
- STEP5, default 37281: CPU cycles to step 5, the last step in 5-step mode.
- CW, default 16: frame cycle counter width. It must satisfy STEP5 < 2^CW.

Ports:
- clk, in, 1: the single system clock. All logic is on posedge.
- rst_n, in, 1: asynchronous, active-low reset.
- cpu_ce, in, 1: one-clk CPU-cycle enable. The frame counter advances only when this is high.
- addr, in, 16: CPU bus address.
- wdata, in, 8: CPU write data.
- we, in, 1: write strobe. It is sampled on a clk edge; each high cycle is one write.
- re, in, 1: read strobe. It is used only to detect reads of $4015.
- inputReg1, out, 8: the $4008 byte. Bit 7 is the control flag; bits 6:0 are the linear reload value.
- inputReg2, out, 8: the $400A byte, timer low.
- inputReg3, out, 8: the $400B byte. Bits 7:3 are the length index; bits 2:0 are timer high.
- linear_reload, out, 1: one-clk pulse on a $400B write.
- quarter_frame, out, 1: one-clk pulse. Drives the triangle linearclk.
- half_frame, out, 1: one-clk pulse. Drives the triangle lengthclk.
- frame_irq, out, 1: frame interrupt flag, level output.

## Operation
Register writes (when we=1):
- $4008, $400A and $400B load inputReg1, inputReg2 and inputReg3 respectively.
- A $400B write also pulses linear_reload.
- A $4017 write loads mode and inhibit:
  - mode = wdata[7]: 0 selects 4-step, 1 selects 5-step.
  - inhibit = wdata[6].
  - wdata[6]=1 also clears frame_irq.
- Writes to any other address have no effect.

Frame counter:
- Registered count `cnt`, CW bits.
- On each cpu_ce, compare cnt against the step constants for the current mode.
- 4-step mode (mode=0):
  - STEP1: quarter.
  - STEP2: quarter and half.
  - STEP3: quarter.
  - STEP4: quarter and half. Also sets frame_irq if inhibit=0. cnt then wraps to 0.
- 5-step mode (mode=1):
  - STEP1: quarter.
  - STEP2: quarter and half.
  - STEP3: quarter.
  - STEP4: nothing.
  - STEP5: quarter and half. cnt then wraps to 0.
- Otherwise on cpu_ce, cnt increments by 1. With cpu_ce=0, cnt holds.
- A $4017 write forces cnt to 0, regardless of cpu_ce.
  - If the new mode is 1, quarter_frame and half_frame both pulse immediately.
  - If the new mode is 0, no pulse.

IRQ clearing:
- frame_irq clears on re=1 with addr=$4015, or on a $4017 write with wdata[6]=1.

Internal states: two frame modes (FOUR_STEP, FIVE_STEP) plus cnt. No other FSM.

## Timing
- Reset values:
  - All three inputReg bytes are 0x00.
  - mode=0, inhibit=0, cnt=0.
  - All pulses are 0.
  - frame_irq=0.
- Register write latency: a write at edge N is visible on inputReg* after edge N.
- linear_reload is high for exactly the cycle after edge N.
- Step pulses are registered and high for exactly one clk. They occur in the cycle after the cpu_ce edge at which cnt equals the step constant.
- After a $4017 write, cnt=0. The first STEP1 quarter pulse follows STEP1+1 further cpu_ce cycles.
- In 5-step mode, the immediate quarter and half pulses from a $4017 write appear the cycle after the write.
- Simultaneous events:
  - A $4017 write on a step-match cycle wins. cnt resets and that step's pulses are suppressed (except the mode-1 immediate pulses).
  - IRQ set and IRQ clear on the same cycle: set wins.
  - Writes with cpu_ce=0 take effect normally.
- Asserting rst_n low mid-frame returns everything to reset values asynchronously. After release, counting restarts from cnt=0 in 4-step mode.

## Structure
- Shared package apu_pkg holds:
  - address constants ADDR_TRI_LINEAR=16'h4008, ADDR_TRI_TLO=16'h400A, ADDR_TRI_THI=16'h400B, ADDR_FRAME=16'h4017, ADDR_STATUS=16'h4015;
  - typedef frame_mode_t (FOUR_STEP, FIVE_STEP);
  - the default STEP constants.
- The natural sub-module is `frame_sequencer`. It holds cnt, the mode, the step decode and the pulse registers.
- The top level holds the address decode, the register bytes, linear_reload and the IRQ flag.

## Test plan
- Reset, then write $4008=0x85, $400A=0x34, $400B=0xF9 -> inputReg1/2/3 read 0x85/0x34/0xF9. linear_reload pulses once, the cycle after the $400B write only.
- cpu_ce=1 every clk, 4-step mode -> quarter pulses at 7458, 14914, 22372 and 29830 clk after reset. Half pulses at 14914 and 29830. frame_irq rises at 29830 and the pattern repeats with a 29830 period.
- Write $4017=0x80 -> quarter and half pulse the next cycle. Then quarter at +7458, +14914, +22372; nothing at +29830; quarter and half at +37282. frame_irq stays 0.
- frame_irq=1, then re with addr=$4015 -> frame_irq=0 next cycle. Repeat with $4017=0x40 -> cleared, and no IRQ at the next step 4.
- $4017 write on the exact cpu_ce cycle of the STEP2 match -> no pulse that cycle, and cnt=0 afterward.
- rst_n low mid-frame with cnt about 20000 -> all outputs at reset values immediately. After release, the first quarter pulse is at 7458 cycles.
